bp_fe_fetch_buffer: RTL and testbench
=====================================

Name: bp_fe_fetch_buffer

Overview:
Parametrised decoupling buffer between the FE memory-response path and instruction issue. It accepts multi-instruction fetch packets (PC, instruction vector, lane-valid mask) over a ready/valid handshake and stores up to els_p packets. It emits one instruction per cycle with its computed PC over a valid/yumi handshake. A flush drops all buffered state for redirects and traps. This is the next-generation FE fetch path: it generalises single-instruction fetch to fetch_width_p lanes with arbitrary lane masks.

Parameters:
vaddr_width_p, 39, virtual PC width
instr_width_p, 32, bits per instruction; lane PC stride = instr_width_p/8 bytes
fetch_width_p, 2, instruction lanes per fetch packet (>=1)
els_p, 4, packet entries (>=2, need not be a power of two)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
flush_i  in  1  drop all entries this cycle
fetch_pc_i  in  vaddr_width_p  PC of lane 0
fetch_instr_i  in  fetch_width_p*instr_width_p  lane k at bits [k*instr_width_p +: instr_width_p]
fetch_mask_i  in  fetch_width_p  lane-valid mask, may be non-contiguous
fetch_v_i  in  1  packet valid
fetch_ready_o  out  1  buffer can accept a packet
instr_pc_o  out  vaddr_width_p  PC of the head instruction
instr_o  out  instr_width_p  head instruction
instr_v_o  out  1  head valid
instr_yumi_i  in  1  consumer takes the head; legal only when instr_v_o=1
count_o  out  clog2(els_p+1)  occupied packet entries

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on reset_i.
- Reset: count_o=0, read and write pointers=0, instr_v_o=0, fetch_ready_o=1. instr_o and instr_pc_o are don't-care while instr_v_o=0. Reset mid-stream discards all entries.
- Storage: per entry, pc, instructions, and a remaining-lane mask rem.
- fetch_ready_o = (count < els_p) & ~flush_i. It depends only on registered count plus flush; there is no pass-through when full.
- Enqueue fires when fetch_v_i & fetch_ready_o & (fetch_mask_i != 0). The entry is written at wptr with rem = fetch_mask_i. wptr wraps from els_p-1 to 0.
- A packet with an all-zero mask is accepted (handshake completes) but not stored.
- Head lane = lowest set bit of rem[rptr].
  - instr_v_o = (count != 0).
  - instr_o = that lane's instruction.
  - instr_pc_o = pc + lane*(instr_width_p/8), modulo 2^vaddr_width_p (wrap at the top of the address space).
- Dequeue on instr_yumi_i clears the lowest set bit of rem[rptr]. If the result is zero, the entry pops: rptr advances with wrap and count decrements.
- Simultaneous enqueue and pop: count is unchanged and both pointers advance.
- An enqueue while count=els_p-1 coincident with a pop is legal.
- flush_i has priority over everything. The next state is count=0 and pointers=0; any enqueue or dequeue in the same cycle is discarded. instr_v_o=0 on the following cycle.
- Minimum latency from enqueue to instr_v_o is 1 cycle (see optional feature).
- Assertion, simulation only: instr_yumi_i & ~instr_v_o is an error.

Optional Feature:
Macro: BP_FE_FETCH_BUFFER_BYPASS_EN.
- Enabled:
  - When count=0, flush_i=0, and an enqueue fires, instr_v_o is asserted combinationally in the same cycle, using the lowest lane of fetch_mask_i.
  - If instr_yumi_i is taken and no other lane remains, nothing is written.
  - Otherwise the entry is written with that lane already cleared from rem.
- Disabled: instr_v_o is driven purely from storage, giving a 1-cycle minimum latency.

Decomposition:
- bp_fe_pkg gains a struct macro, declare_bp_fe_fetch_pkt_s(vaddr_width_p, instr_width_p, fetch_width_p), with fields pc, instr, mask, plus a width macro for the struct.
- Lane stride is a localparam.
- One sub-module: bp_fe_fetch_lane_sel. It is combinational: given rem it returns the lowest-set-lane index, a one-hot bit, a next-rem value, and a last flag. It is instantiated once for the head and, under the bypass macro, once more for the input.

Test Plan:
- Defaults; reset; enqueue pc=0x8000_0000, mask=2'b11 -> next cycle instr_pc_o=0x8000_0000 lane0; after yumi, 0x8000_0004 lane1; after second yumi, count_o=0 and instr_v_o=0.
- mask=2'b10, pc=0x100 -> single output with instr_pc_o=0x104 and lane-1 data; mask=2'b00 -> handshake completes, count_o stays 0.
- Enqueue 4 packets with no yumi -> count_o=4, fetch_ready_o=0. Enqueue with simultaneous last-lane yumi at count 3 -> count_o stays 3; wptr and rptr wrap 3->0 correctly.
- Flush asserted with fetch_v_i=1 and instr_yumi_i=1 at count_o=2 -> next cycle count_o=0 and instr_v_o=0; the flushed-cycle packet never appears.
- pc=0x7F_FFFF_FFFC, mask=2'b11 -> lane-1 instr_pc_o=0x00_0000_0000 (wrap).
- BYPASS_EN, count 0: enqueue mask=2'b01 with same-cycle yumi -> instr_v_o=1 that cycle and count_o stays 0. Without the macro: instr_v_o=0 that cycle, 1 next cycle.

Source files
------------

// File: rtl/bp_fe_fetch_buffer_pkg.sv
// Shared types and helpers for the FE fetch buffer.
// The struct macro builds a fetch-packet payload sized by the caller's parameters.
// Optional feature macro: BP_FE_FETCH_BUFFER_BYPASS_EN (same-cycle issue from an empty buffer).
`ifndef BP_FE_FETCH_BUFFER_PKG_SV
`define BP_FE_FETCH_BUFFER_PKG_SV

package bp_fe_fetch_buffer_pkg;

    // Byte distance between consecutive instruction lanes.
    function automatic int unsigned bp_fe_lane_stride(input int unsigned instr_width);
        return instr_width / 8;
    endfunction

    // clog2 that never returns zero, so index vectors always have at least one bit.
    function automatic int unsigned bp_fe_safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`define BP_FE_DECLARE_FETCH_PKT_S(vaddr_width_mp, instr_width_mp, fetch_width_mp) \
    typedef struct packed { \
        logic [(vaddr_width_mp)-1:0]                    pc;    \
        logic [((fetch_width_mp)*(instr_width_mp))-1:0] instr; \
        logic [(fetch_width_mp)-1:0]                    mask;  \
    } bp_fe_fetch_pkt_s

`define BP_FE_FETCH_PKT_WIDTH(vaddr_width_mp, instr_width_mp, fetch_width_mp) \
    ((vaddr_width_mp) + ((fetch_width_mp)*(instr_width_mp)) + (fetch_width_mp))

`endif

// File: rtl/bp_fe_fetch_buffer_lane_sel.sv
// Combinational lowest-set-lane picker for a lane-valid mask.
// Returns the lane index, its one-hot, the mask with that lane cleared, and a last flag.
module bp_fe_fetch_lane_sel
    import bp_fe_fetch_buffer_pkg::*;
#(
    parameter  int unsigned fetch_width_p = 2,
    localparam int unsigned lane_width_lp = bp_fe_safe_clog2(fetch_width_p)
)
(
    input  logic [fetch_width_p-1:0] rem_i,
    output logic [lane_width_lp-1:0] lane_o,
    output logic [fetch_width_p-1:0] lane_oh_o,
    output logic [fetch_width_p-1:0] rem_next_o,
    output logic                     last_o
);

    // Isolate the lowest set bit and derive the remaining mask.
    always_comb begin
        lane_oh_o  = rem_i & (~rem_i + fetch_width_p'(1));
        rem_next_o = rem_i & ~lane_oh_o;
        last_o     = (rem_next_o == '0);
    end

    // Encode the position of the lowest set bit.
    always_comb begin
        logic found;
        lane_o = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < fetch_width_p; i++) begin
            if (rem_i[i] && !found) begin
                lane_o = lane_width_lp'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// Decoupling buffer between FE memory responses and instruction issue.
// Stores up to els_p multi-lane fetch packets and issues one instruction per cycle.
// Optional feature macro: BP_FE_FETCH_BUFFER_BYPASS_EN (issue from input when empty).
module bp_fe_fetch_buffer
    import bp_fe_fetch_buffer_pkg::*;
#(
    parameter  int unsigned vaddr_width_p  = 39,
    parameter  int unsigned instr_width_p  = 32,
    parameter  int unsigned fetch_width_p  = 2,
    parameter  int unsigned els_p          = 4,
    localparam int unsigned count_width_lp = $clog2(els_p + 1)
)
(
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   flush_i,
    input  logic [vaddr_width_p-1:0]               fetch_pc_i,
    input  logic [fetch_width_p*instr_width_p-1:0] fetch_instr_i,
    input  logic [fetch_width_p-1:0]               fetch_mask_i,
    input  logic                                   fetch_v_i,
    output logic                                   fetch_ready_o,
    output logic [vaddr_width_p-1:0]               instr_pc_o,
    output logic [instr_width_p-1:0]               instr_o,
    output logic                                   instr_v_o,
    input  logic                                   instr_yumi_i,
    output logic [count_width_lp-1:0]              count_o
);

    localparam int unsigned ptr_width_lp   = bp_fe_safe_clog2(els_p);
    localparam int unsigned lane_width_lp  = bp_fe_safe_clog2(fetch_width_p);
    localparam int unsigned lane_stride_lp = bp_fe_lane_stride(instr_width_p);

    `BP_FE_DECLARE_FETCH_PKT_S(vaddr_width_p, instr_width_p, fetch_width_p);

    bp_fe_fetch_pkt_s           mem_r [els_p];
    logic [ptr_width_lp-1:0]    rptr_r, wptr_r;
    logic [count_width_lp-1:0]  count_r;

    bp_fe_fetch_pkt_s           head_pkt;
    logic [lane_width_lp-1:0]   head_lane;
    logic [fetch_width_p-1:0]   head_oh, head_rem_next;
    logic                       head_last;
    logic [instr_width_p-1:0]   head_instr;
    logic [vaddr_width_p-1:0]   head_pc;

    logic                       stored_v, enq_fire, deq, pop, wr_v;
    logic [fetch_width_p-1:0]   wr_mask;

    // Wrap a pointer from els_p-1 back to zero.
    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    assign head_pkt = mem_r[rptr_r];

    bp_fe_fetch_lane_sel #(.fetch_width_p(fetch_width_p)) head_sel (
        .rem_i      (head_pkt.mask),
        .lane_o     (head_lane),
        .lane_oh_o  (head_oh),
        .rem_next_o (head_rem_next),
        .last_o     (head_last)
    );

    // Head instruction mux and lane PC (wraps modulo the address width).
    always_comb begin
        head_instr = '0;
        for (int unsigned k = 0; k < fetch_width_p; k++) begin
            if (head_oh[k]) head_instr |= head_pkt.instr[k*instr_width_p +: instr_width_p];
        end
        head_pc = head_pkt.pc
                + vaddr_width_p'(head_lane) * vaddr_width_p'(lane_stride_lp);
    end

    // Handshake qualifiers; ready depends only on registered count and flush.
    always_comb begin
        fetch_ready_o = (count_r < count_width_lp'(els_p)) & ~flush_i;
        enq_fire      = fetch_v_i & fetch_ready_o & (|fetch_mask_i);
        stored_v      = (count_r != '0);
        deq           = instr_yumi_i & stored_v;
        pop           = deq & head_last;
        count_o       = count_r;
    end

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    logic [lane_width_lp-1:0]   in_lane;
    logic [fetch_width_p-1:0]   in_oh, in_rem_next;
    logic                       in_last;
    logic [instr_width_p-1:0]   in_instr;
    logic [vaddr_width_p-1:0]   in_pc;
    logic                       bypass_v, bypass_take;

    bp_fe_fetch_lane_sel #(.fetch_width_p(fetch_width_p)) in_sel (
        .rem_i      (fetch_mask_i),
        .lane_o     (in_lane),
        .lane_oh_o  (in_oh),
        .rem_next_o (in_rem_next),
        .last_o     (in_last)
    );

    // Issue straight from the incoming packet when the buffer is empty.
    always_comb begin
        in_instr = '0;
        for (int unsigned k = 0; k < fetch_width_p; k++) begin
            if (in_oh[k]) in_instr |= fetch_instr_i[k*instr_width_p +: instr_width_p];
        end
        in_pc       = fetch_pc_i + vaddr_width_p'(in_lane) * vaddr_width_p'(lane_stride_lp);
        bypass_v    = ~stored_v & enq_fire;
        bypass_take = bypass_v & instr_yumi_i;
        instr_v_o   = stored_v | bypass_v;
        instr_o     = stored_v ? head_instr : in_instr;
        instr_pc_o  = stored_v ? head_pc    : in_pc;
        wr_v        = enq_fire & ~(bypass_take & in_last);
        wr_mask     = bypass_take ? in_rem_next : fetch_mask_i;
    end
`else
    // Issue only from storage: one cycle minimum enqueue-to-valid latency.
    always_comb begin
        instr_v_o  = stored_v;
        instr_o    = head_instr;
        instr_pc_o = head_pc;
        wr_v       = enq_fire;
        wr_mask    = fetch_mask_i;
    end
`endif

    // Packet storage: enqueue writes a new entry, dequeue retires one lane of the head.
    always_ff @(posedge clk_i) begin
        if (wr_v) begin
            mem_r[wptr_r] <= '{pc: fetch_pc_i, instr: fetch_instr_i, mask: wr_mask};
        end
        if (deq && !flush_i && !pop) begin
            mem_r[rptr_r].mask <= head_rem_next;
        end
    end

    // Pointers and occupancy; reset and flush both empty the buffer.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (wr_v) wptr_r <= ptr_inc(wptr_r);
            if (pop)  rptr_r <= ptr_inc(rptr_r);
            count_r <= count_r + count_width_lp'(wr_v) - count_width_lp'(pop);
        end
    end

`ifndef SYNTHESIS
    // The consumer may only take an instruction that is being offered.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(instr_yumi_i && !instr_v_o))
                else $error("instr_yumi_i asserted while instr_v_o is low");
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Self-checking bench for bp_fe_fetch_buffer: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_bp_fe_fetch_buffer;

    localparam int unsigned VW  = 39;
    localparam int unsigned IW  = 32;
    localparam int unsigned FW  = 2;
    localparam int unsigned ELS = 4;
    localparam int unsigned CW  = $clog2(ELS + 1);
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_i, flush_i, fetch_v_i, instr_yumi_i;
    logic [VW-1:0]     fetch_pc_i;
    logic [FW*IW-1:0]  fetch_instr_i;
    logic [FW-1:0]     fetch_mask_i;
    logic              fetch_ready_o, instr_v_o;
    logic [VW-1:0]     instr_pc_o;
    logic [IW-1:0]     instr_o;
    logic [CW-1:0]     count_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [VW-1:0]    pc;
        logic [FW*IW-1:0] instr;
        logic [FW-1:0]    rem;
    } pkt_t;
    pkt_t q[$];

    bp_fe_fetch_buffer #(.vaddr_width_p(VW), .instr_width_p(IW), .fetch_width_p(FW), .els_p(ELS)) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i), .fetch_mask_i(fetch_mask_i),
        .fetch_v_i(fetch_v_i), .fetch_ready_o(fetch_ready_o),
        .instr_pc_o(instr_pc_o), .instr_o(instr_o), .instr_v_o(instr_v_o),
        .instr_yumi_i(instr_yumi_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int low_lane(input logic [FW-1:0] r);
        for (int i = 0; i < int'(FW); i++) if (r[i]) return i;
        return 0;
    endfunction

    function automatic logic [FW-1:0] clr_low(input logic [FW-1:0] r);
        logic [FW-1:0] o;
        o = r;
        o[low_lane(r)] = 1'b0;
        return o;
    endfunction

    function automatic logic byp_now();
        return BYP && q.size() == 0 && fetch_v_i && !flush_i && fetch_mask_i != '0;
    endfunction

    function automatic logic exp_v();
        return q.size() != 0 || byp_now();
    endfunction

    function automatic logic exp_ready();
        return q.size() < ELS && !flush_i;
    endfunction

    function automatic logic [VW-1:0] exp_pc();
        int l;
        if (q.size() != 0) begin
            l = low_lane(q[0].rem);
            return q[0].pc + VW'(l * (IW / 8));
        end
        l = low_lane(fetch_mask_i);
        return fetch_pc_i + VW'(l * (IW / 8));
    endfunction

    function automatic logic [IW-1:0] exp_instr();
        logic [FW*IW-1:0] v;
        int l;
        if (q.size() != 0) begin
            v = q[0].instr;
            l = low_lane(q[0].rem);
        end else begin
            v = fetch_instr_i;
            l = low_lane(fetch_mask_i);
        end
        return v[l*IW +: IW];
    endfunction

    task automatic model_step();
        logic fire;
        pkt_t p;
        if (reset_i || flush_i) begin
            q.delete();
            return;
        end
        fire    = fetch_v_i && q.size() < ELS && fetch_mask_i != '0;
        p.pc    = fetch_pc_i;
        p.instr = fetch_instr_i;
        p.rem   = fetch_mask_i;
        if (BYP && fire && q.size() == 0) begin
            if (instr_yumi_i) p.rem = clr_low(p.rem);
            if (p.rem != '0) q.push_back(p);
        end else begin
            if (instr_yumi_i && q.size() != 0) begin
                q[0].rem = clr_low(q[0].rem);
                if (q[0].rem == '0) void'(q.pop_front());
            end
            if (fire) q.push_back(p);
        end
    endtask

    task automatic idle();
        reset_i = 1'b0; flush_i = 1'b0; fetch_v_i = 1'b0; instr_yumi_i = 1'b0;
        fetch_pc_i = '0; fetch_instr_i = '0; fetch_mask_i = '0;
    endtask

    // Advance one clock: model follows the DUT edge, inputs return to idle afterwards.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        idle();
    endtask

    task automatic put(input logic [VW-1:0] pc, input logic [FW*IW-1:0] ins, input logic [FW-1:0] m);
        fetch_v_i = 1'b1; fetch_pc_i = pc; fetch_instr_i = ins; fetch_mask_i = m;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_i = 1'b1; tick();
        reset_i = 1'b1; tick();
        total++; if (count_o !== CW'(0)) begin bad++; $display("FAIL reset_count got %0d exp 0", count_o); end
        total++; if (instr_v_o !== 1'b0) begin bad++; $display("FAIL reset_v got %b exp 0", instr_v_o); end
        total++; if (fetch_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b exp 1", fetch_ready_o); end
        put(39'h40, 64'h11, 2'b01); tick();
        put(39'h50, 64'h22, 2'b11); tick();
        reset_i = 1'b1; tick();
        total++; if (count_o !== CW'(0) || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL midstream_reset got count=%0d v=%b exp 0/0", count_o, instr_v_o);
        end
    endtask

    task automatic test_basic();
        put(39'h8000_0000, {32'hBBBB_0001, 32'hAAAA_0000}, 2'b11);
        #1;
        total++; if (instr_v_o !== BYP) begin bad++; $display("FAIL enq_cycle_v got %b exp %b", instr_v_o, BYP); end
        tick();
        total++; if (instr_v_o !== 1'b1 || count_o !== CW'(1)) begin
            bad++; $display("FAIL basic_v got v=%b count=%0d exp 1/1", instr_v_o, count_o);
        end
        total++; if (instr_pc_o !== 39'h8000_0000 || instr_o !== 32'hAAAA_0000) begin
            bad++; $display("FAIL basic_lane0 got pc=%h ins=%h exp 8000_0000/aaaa0000", instr_pc_o, instr_o);
        end
        instr_yumi_i = 1'b1; tick();
        total++; if (instr_pc_o !== 39'h8000_0004 || instr_o !== 32'hBBBB_0001 || count_o !== CW'(1)) begin
            bad++; $display("FAIL basic_lane1 got pc=%h ins=%h count=%0d exp 8000_0004/bbbb0001/1", instr_pc_o, instr_o, count_o);
        end
        instr_yumi_i = 1'b1; tick();
        total++; if (count_o !== CW'(0) || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL basic_drain got count=%0d v=%b exp 0/0", count_o, instr_v_o);
        end
    endtask

    task automatic test_sparse_mask();
        put(39'h100, {32'hC1C1_C1C1, 32'hC0C0_C0C0}, 2'b10); tick();
        total++; if (instr_pc_o !== 39'h104 || instr_o !== 32'hC1C1_C1C1 || instr_v_o !== 1'b1) begin
            bad++; $display("FAIL sparse_lane1 got pc=%h ins=%h v=%b exp 104/c1c1c1c1/1", instr_pc_o, instr_o, instr_v_o);
        end
        instr_yumi_i = 1'b1; tick();
        total++; if (count_o !== CW'(0) || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL sparse_single got count=%0d v=%b exp 0/0", count_o, instr_v_o);
        end
        put(39'h200, 64'hDEAD, 2'b00);
        #1;
        total++; if (fetch_ready_o !== 1'b1 || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL zero_mask_hs got ready=%b v=%b exp 1/0", fetch_ready_o, instr_v_o);
        end
        tick();
        total++; if (count_o !== CW'(0) || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL zero_mask_store got count=%0d v=%b exp 0/0", count_o, instr_v_o);
        end
    endtask

    task automatic test_full_wrap();
        logic [VW-1:0] order [3];
        order[0] = 39'h1020; order[1] = 39'h1030; order[2] = 39'h2000;
        for (int i = 0; i < 4; i++) begin
            put(VW'(32'h1000 + 16 * i), 64'(i), 2'b01); tick();
        end
        total++; if (count_o !== CW'(4) || fetch_ready_o !== 1'b0) begin
            bad++; $display("FAIL full got count=%0d ready=%b exp 4/0", count_o, fetch_ready_o);
        end
        instr_yumi_i = 1'b1; tick();
        put(39'h2000, 64'h99, 2'b01); instr_yumi_i = 1'b1;
        #1;
        total++; if (fetch_ready_o !== 1'b1 || instr_pc_o !== 39'h1010) begin
            bad++; $display("FAIL enq_pop_pre got ready=%b pc=%h exp 1/1010", fetch_ready_o, instr_pc_o);
        end
        tick();
        total++; if (count_o !== CW'(3)) begin bad++; $display("FAIL enq_pop_count got %0d exp 3", count_o); end
        for (int i = 0; i < 3; i++) begin
            total++; if (instr_pc_o !== order[i] || instr_v_o !== 1'b1) begin
                bad++; $display("FAIL wrap_order%0d got pc=%h v=%b exp %h/1", i, instr_pc_o, instr_v_o, order[i]);
            end
            instr_yumi_i = 1'b1; tick();
        end
        total++; if (count_o !== CW'(0)) begin bad++; $display("FAIL wrap_drain got %0d exp 0", count_o); end
    endtask

    task automatic test_flush();
        put(39'h3000, 64'h1, 2'b11); tick();
        put(39'h3010, 64'h2, 2'b11); tick();
        total++; if (count_o !== CW'(2)) begin bad++; $display("FAIL flush_pre got %0d exp 2", count_o); end
        put(39'h3020, 64'h3, 2'b11); instr_yumi_i = 1'b1; flush_i = 1'b1;
        #1;
        total++; if (fetch_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready got %b exp 0", fetch_ready_o); end
        tick();
        total++; if (count_o !== CW'(0) || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL flush_post got count=%0d v=%b exp 0/0", count_o, instr_v_o);
        end
        tick();
        total++; if (count_o !== CW'(0) || instr_v_o !== 1'b0) begin
            bad++; $display("FAIL flush_ghost got count=%0d v=%b exp 0/0", count_o, instr_v_o);
        end
    endtask

    task automatic test_pc_wrap();
        put(39'h7F_FFFF_FFFC, {32'h2222_2222, 32'h1111_1111}, 2'b11); tick();
        total++; if (instr_pc_o !== 39'h7F_FFFF_FFFC) begin bad++; $display("FAIL pcwrap_l0 got %h exp 7ffffffffc", instr_pc_o); end
        instr_yumi_i = 1'b1; tick();
        total++; if (instr_pc_o !== 39'h0 || instr_o !== 32'h2222_2222) begin
            bad++; $display("FAIL pcwrap_l1 got pc=%h ins=%h exp 0/22222222", instr_pc_o, instr_o);
        end
        instr_yumi_i = 1'b1; tick();
    endtask

    task automatic test_bypass();
        put(39'h500, {32'h0, 32'h5555_5555}, 2'b01);
        instr_yumi_i = BYP;
        #1;
        total++; if (instr_v_o !== BYP) begin bad++; $display("FAIL byp_same_cycle got %b exp %b", instr_v_o, BYP); end
        if (BYP) begin
            total++; if (instr_pc_o !== 39'h500 || instr_o !== 32'h5555_5555) begin
                bad++; $display("FAIL byp_data got pc=%h ins=%h exp 500/55555555", instr_pc_o, instr_o);
            end
        end
        tick();
        total++; if (count_o !== CW'(!BYP) || instr_v_o !== !BYP) begin
            bad++; $display("FAIL byp_next got count=%0d v=%b exp %0d/%b", count_o, instr_v_o, !BYP, !BYP);
        end
        if (!BYP) begin instr_yumi_i = 1'b1; tick(); end
    endtask

    task automatic test_random();
        logic [VW-1:0] epc;
        logic [IW-1:0] ein;
        logic          ev;
        for (int c = 0; c < 1500; c++) begin
            fetch_v_i     = ($urandom_range(0, 3) != 0);
            fetch_pc_i    = ($urandom_range(0, 7) == 0) ? VW'(39'h7F_FFFF_FFF8 + VW'($urandom_range(0, 7) * 4))
                                                        : VW'({$urandom, $urandom});
            fetch_instr_i = {$urandom, $urandom};
            fetch_mask_i  = FW'($urandom);
            flush_i       = ($urandom_range(0, 39) == 0);
            ev            = exp_v();
            instr_yumi_i  = ev && ($urandom_range(0, 2) != 0);
            #1;
            epc = exp_pc();
            ein = exp_instr();
            total++; if (count_o !== CW'(q.size())) begin bad++; $display("FAIL rnd_count c=%0d got %0d exp %0d", c, count_o, q.size()); end
            total++; if (fetch_ready_o !== exp_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, fetch_ready_o, exp_ready()); end
            total++; if (instr_v_o !== ev) begin bad++; $display("FAIL rnd_v c=%0d got %b exp %b", c, instr_v_o, ev); end
            if (ev) begin
                total++; if (instr_pc_o !== epc || instr_o !== ein) begin
                    bad++; $display("FAIL rnd_head c=%0d got pc=%h ins=%h exp %h/%h", c, instr_pc_o, instr_o, epc, ein);
                end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_basic();
        test_sparse_mask();
        test_full_wrap();
        test_flush();
        test_pc_wrap();
        test_bypass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
